// File: rtl/rx_intf_dma_credit_pkg.sv
// Shared definitions for the rx DMA credit scheduler: state encoding and
// default widths.
package rx_intf_dma_credit_pkg;

  localparam int unsigned CREDIT_WIDTH   = 6;
  localparam int unsigned TIMEOUT_WIDTH  = 13;
  localparam int unsigned DROP_CNT_WIDTH = 16;

  typedef enum logic {
    IDLE     = 1'b0,
    INFLIGHT = 1'b1
  } state_e;

endpackage

// File: rtl/rx_intf_dma_timeout_timer.sv
// Tick-driven timeout timer. Cleared on request, advanced by one per tick,
// saturating at all-ones so a maximal threshold never fires.
// expired_o = (timer > top_i), evaluated on the registered count.
module rx_intf_dma_timeout_timer #(
  parameter int unsigned WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             tick_i,
  input  logic [WIDTH-1:0] top_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] timer_q;
  logic [WIDTH-1:0] timer_d;

  // Next count: clear has priority over a coincident tick.
  always_comb begin
    timer_d = timer_q;
    if (clear_i) begin
      timer_d = '0;
    end else if (tick_i && (timer_q != '1)) begin
      timer_d = timer_q + WIDTH'(1);
    end
  end

  // Timer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign expired_o = (timer_q > top_i);

endmodule

// File: rtl/rx_intf_dma_credit_ctrl.sv
// Credit-based rx DMA scheduler: grants one packet at a time against a pool
// of PS rx buffer credits, detects completion on the s2mm_intr rising edge
// and abandons stuck transfers after a microsecond-tick timeout.
// Optional statistics counters are enabled by RX_INTF_DMA_CREDIT_STAT_EN.
module rx_intf_dma_credit_ctrl #(
  parameter int unsigned CREDIT_WIDTH   = rx_intf_dma_credit_pkg::CREDIT_WIDTH,
  parameter int unsigned TIMEOUT_WIDTH  = rx_intf_dma_credit_pkg::TIMEOUT_WIDTH,
  parameter int unsigned DROP_CNT_WIDTH = rx_intf_dma_credit_pkg::DROP_CNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      enable,
  input  logic                      credit_init,
  input  logic [CREDIT_WIDTH-1:0]   credit_init_val,
  input  logic                      buf_release,
  input  logic                      pkt_req,
  input  logic                      s2mm_intr,
  input  logic                      tsf_pulse_1M,
  input  logic [TIMEOUT_WIDTH-1:0]  timeout_top,
  output logic                      pkt_grant,
  output logic                      pkt_drop,
  output logic                      pkt_done,
  output logic                      pkt_timeout,
  output logic                      busy,
  output logic [CREDIT_WIDTH-1:0]   credit_avail,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt,
  output logic [31:0]               grant_cnt,
  output logic [15:0]               timeout_cnt
);

  import rx_intf_dma_credit_pkg::*;

  state_e                    state_q;
  logic                      s2mm_intr_q;
  logic                      pkt_grant_q;
  logic                      pkt_drop_q;
  logic                      pkt_done_q;
  logic                      pkt_timeout_q;
  logic [CREDIT_WIDTH-1:0]   credit_q;
  logic [CREDIT_WIDTH-1:0]   credit_d;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q;

  logic                      s2mm_rise;
  logic                      grant_ev;
  logic                      drop_ev;
  logic                      done_ev;
  logic                      tmo_ev;
  logic                      expired;
  logic [1:0]                credit_inc;
  logic                      credit_up;
  logic [CREDIT_WIDTH+1:0]   credit_sum;

  rx_intf_dma_timeout_timer #(
    .WIDTH (TIMEOUT_WIDTH)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rstn),
    .clear_i   (grant_ev),
    .tick_i    (tsf_pulse_1M && (state_q == INFLIGHT)),
    .top_i     (timeout_top),
    .expired_o (expired)
  );

  // Decision events for this cycle; done beats a coincident timeout.
  always_comb begin
    s2mm_rise = s2mm_intr && !s2mm_intr_q;
    grant_ev  = (state_q == IDLE) && pkt_req && enable && (credit_q != '0);
    drop_ev   = pkt_req && !grant_ev;
    done_ev   = (state_q == INFLIGHT) && s2mm_rise;
    tmo_ev    = (state_q == INFLIGHT) && !s2mm_rise && expired;
  end

  // Net credit update in one step; only a net increase is capped at the
  // ceiling, and a grant needs a nonzero count so the sum never underflows.
  always_comb begin
    credit_inc = {1'b0, buf_release} + {1'b0, tmo_ev};
    credit_up  = credit_inc > {1'b0, grant_ev};
    credit_sum = {2'b00, credit_q}
               + {{CREDIT_WIDTH{1'b0}}, credit_inc}
               - {{(CREDIT_WIDTH+1){1'b0}}, grant_ev};
    if (credit_init) begin
      credit_d = credit_init_val;
    end else if (credit_up && (credit_sum > {2'b00, credit_init_val})) begin
      credit_d = credit_init_val;
    end else begin
      credit_d = credit_sum[CREDIT_WIDTH-1:0];
    end
  end

  // Scheduler FSM with registered pulses, credit and drop counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      s2mm_intr_q   <= 1'b0;
      pkt_grant_q   <= 1'b0;
      pkt_drop_q    <= 1'b0;
      pkt_done_q    <= 1'b0;
      pkt_timeout_q <= 1'b0;
      credit_q      <= '0;
      drop_cnt_q    <= '0;
    end else begin
      s2mm_intr_q   <= s2mm_intr;
      pkt_grant_q   <= grant_ev;
      pkt_drop_q    <= drop_ev;
      pkt_done_q    <= done_ev;
      pkt_timeout_q <= tmo_ev;
      credit_q      <= credit_d;
      if (drop_ev && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + DROP_CNT_WIDTH'(1);
      end
      case (state_q)
        IDLE: begin
          if (grant_ev) begin
            state_q <= INFLIGHT;
          end
        end
        INFLIGHT: begin
          if (done_ev || tmo_ev) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef RX_INTF_DMA_CREDIT_STAT_EN
  logic [31:0] grant_cnt_q;
  logic [15:0] timeout_cnt_q;

  // Statistics: grants wrap, timeouts saturate; credit_init clears both.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grant_cnt_q   <= '0;
      timeout_cnt_q <= '0;
    end else if (credit_init) begin
      grant_cnt_q   <= '0;
      timeout_cnt_q <= '0;
    end else begin
      if (grant_ev) begin
        grant_cnt_q <= grant_cnt_q + 32'd1;
      end
      if (tmo_ev && (timeout_cnt_q != '1)) begin
        timeout_cnt_q <= timeout_cnt_q + 16'd1;
      end
    end
  end

  assign grant_cnt   = grant_cnt_q;
  assign timeout_cnt = timeout_cnt_q;
`else
  assign grant_cnt   = '0;
  assign timeout_cnt = '0;
`endif

  assign pkt_grant    = pkt_grant_q;
  assign pkt_drop     = pkt_drop_q;
  assign pkt_done     = pkt_done_q;
  assign pkt_timeout  = pkt_timeout_q;
  assign busy         = (state_q == INFLIGHT);
  assign credit_avail = credit_q;
  assign drop_cnt     = drop_cnt_q;

endmodule

// File: doc/rx_intf_dma_credit_ctrl.md
Name: rx_intf_dma_credit_ctrl

Overview:
Credit-based scheduler that decides whether each received packet may start an rx DMA transfer to the PS.
- Tracks free PS rx buffers as credits and serialises transfers: at most one packet in flight.
- Detects DMA completion from the s2mm_intr rising edge and recovers from stuck transfers with a 1 µs-tick timeout.
- Sits between the rx header-insert state machine (requester) and the m_axis start logic; drives the go/drop decision that replaces the direct block-DMA input.

Parameters:
CREDIT_WIDTH, 6, width of the credit counter and credit_init_val; max credits 2^CREDIT_WIDTH-1
TIMEOUT_WIDTH, 13, width of the timeout timer and timeout_top
DROP_CNT_WIDTH, 16, width of the saturating drop counter

Ports:
clk  in  1  block clock
rstn  in  1  asynchronous active-low reset
enable  in  1  1 = grants allowed; 0 = every request dropped
credit_init  in  1  pulse: load credit counter from credit_init_val
credit_init_val  in  CREDIT_WIDTH  number of PS rx buffers; also the credit ceiling
buf_release  in  1  pulse: PS has consumed one rx buffer (credit return)
pkt_req  in  1  pulse: packet header inserted, requesting a DMA decision
s2mm_intr  in  1  AXI DMA s2mm interrupt level
tsf_pulse_1M  in  1  1 µs tick
timeout_top  in  TIMEOUT_WIDTH  timeout threshold in µs
pkt_grant  out  1  pulse: start the DMA transfer
pkt_drop  out  1  pulse: discard the packet (reset m_axis)
pkt_done  out  1  pulse: in-flight transfer completed
pkt_timeout  out  1  pulse: in-flight transfer abandoned
busy  out  1  a transfer is in flight
credit_avail  out  CREDIT_WIDTH  current credit count
drop_cnt  out  DROP_CNT_WIDTH  saturating count of drops
grant_cnt  out  32  statistics; see Optional Feature
timeout_cnt  out  16  statistics; see Optional Feature

Behaviour:
- Reset (async, rstn=0):
  - all outputs 0; credit_avail=0; state IDLE; timer 0.
  - s2mm_intr edge register = 0.
- States:
  - IDLE (busy=0): wait for a request.
  - INFLIGHT (busy=1): a granted transfer is running.
- Edge detection: s2mm_rise = s2mm_intr & ~s2mm_intr_d, where s2mm_intr_d is registered every cycle.
- IDLE, pkt_req=1:
  - enable=1 and credit_avail>0: pkt_grant=1 next cycle, credit decremented, timer cleared, go to INFLIGHT.
  - otherwise: pkt_drop=1 next cycle, drop_cnt incremented (saturates at all-ones), stay IDLE.
- INFLIGHT:
  - Timer increments on tsf_pulse_1M.
  - s2mm_rise: pkt_done=1, go to IDLE.
  - Else timer > timeout_top: pkt_timeout=1, credit incremented (buffer not consumed), go to IDLE.
  - s2mm_rise and timeout in the same cycle: done wins, no credit refund.
  - pkt_req while INFLIGHT: pkt_drop=1, drop_cnt incremented.
- Latency: every output pulse is registered, one cycle after its cause, and exactly one cycle wide.
- Credit arithmetic, with net = buf_release - grant + timeout_refund applied in one update:
  - grant and buf_release in the same cycle leave the count unchanged.
  - Increments saturate at credit_init_val; the count never wraps below 0.
- credit_init:
  - Overrides all same-cycle credit arithmetic: credit_avail = credit_init_val.
  - State is unchanged: an in-flight transfer continues.
  - Its eventual timeout refund is still capped at credit_init_val.
- enable 1→0 while INFLIGHT: the current transfer runs to done or timeout; enable gates only new grants.
- timeout_top=0: timeout fires on the first tsf_pulse_1M after the grant.

Optional Feature:
Macro RX_INTF_DMA_CREDIT_STAT_EN.
- Defined:
  - grant_cnt counts pkt_grant pulses and wraps at 2^32.
  - timeout_cnt counts pkt_timeout pulses and saturates at 16'hFFFF.
  - Both clear on reset and on credit_init.
- Undefined: grant_cnt and timeout_cnt are constant 0 and no counter registers are synthesised.

Decomposition:
- Package rx_intf_dma_credit_pkg:
  - state encodings IDLE=1'b0, INFLIGHT=1'b1.
  - default width constants CREDIT_WIDTH, TIMEOUT_WIDTH, DROP_CNT_WIDTH.
- Sub-module rx_intf_dma_timeout_timer:
  - clear/advance on tick; outputs expired = (timer > top).
  - reused later for the m_axis tlast auto-recover timeout.

Test Plan:
- Grant and done: credit_init_val=4 loaded, enable=1, pkt_req → pkt_grant one cycle later, credit_avail=3, busy=1; s2mm_intr 0→1 → pkt_done, busy=0.
- Credit exhaustion: load 2, three grant/done cycles with no buf_release → third pkt_req gives pkt_drop, drop_cnt=1, credit_avail stays 0. One buf_release → credit_avail=1, next pkt_req granted.
- Timeout refund: timeout_top=3, grant with no s2mm_intr, 4 tsf_pulse_1M pulses → pkt_timeout on the 4th, credit_avail back to 4. s2mm_rise on the same cycle as expiry → pkt_done only, credit_avail=3.
- Busy drop and simultaneity:
  - pkt_req while INFLIGHT → pkt_drop, drop_cnt increments.
  - grant and buf_release in the same cycle → credit_avail unchanged.
  - buf_release at credit_avail=credit_init_val → stays at the ceiling.
- Reset mid-transfer: assert rstn=0 asynchronously while INFLIGHT → busy, credit_avail and all pulses 0 immediately. After release, pkt_req with no credit_init → pkt_drop.
- Stats, with RX_INTF_DMA_CREDIT_STAT_EN: 5 grants and 2 timeouts → grant_cnt=5, timeout_cnt=2. Without the macro → both read 0.
